// File: rtl/tl_mon_pkg.sv
// Shared types and lamp encodings for the traffic-light safety monitor.
// Used by the monitor, its lamp decoder and any bench that drives lamp vectors.
package tl_mon_pkg;

  // Lamp vectors are {red, yellow, green} for vehicles and {red, green} for pedestrians.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [1:0] PEA_RED     = 2'b10;
  localparam logic [1:0] PEA_GREEN   = 2'b01;

  localparam logic [4:0] SEC_MAX = 5'd31;

  typedef enum logic [2:0] {
    P_ALLRED = 3'd0,
    P_MG     = 3'd1,
    P_MY     = 3'd2,
    P_SG     = 3'd3,
    P_SY     = 3'd4,
    P_PG     = 3'd5,
    P_BAD    = 3'd6
  } phase_t;

  typedef enum logic [3:0] {
    M_SYNC,
    M_RESET,
    M_MG,
    M_MY,
    M_SG,
    M_SY,
    M_PG,
    M_PR,
    M_FAULT
  } mon_state_t;

  typedef enum logic [2:0] {
    F_NONE     = 3'd0,
    F_CONFLICT = 3'd1,
    F_SEQUENCE = 3'd2,
    F_SHORT    = 3'd3,
    F_LONG     = 3'd4
  } fault_t;

  // While resynchronising, the monitor simply adopts whatever legal phase it sees.
  function automatic mon_state_t sync_target(input phase_t p);
    mon_state_t s;
    case (p)
      P_ALLRED: s = M_RESET;
      P_MG:     s = M_MG;
      P_MY:     s = M_MY;
      P_SG:     s = M_SG;
      P_SY:     s = M_SY;
      P_PG:     s = M_PG;
      default:  s = M_SYNC;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// Purely combinational decode of the three lamp vectors into a controller phase.
// Any pattern the controller never drives legitimately decodes to P_BAD.
module tl_phase_decode
  import tl_mon_pkg::*;
(
  input  logic [2:0] i_main,
  input  logic [2:0] i_sec,
  input  logic [1:0] i_pea,
  output phase_t     o_phase
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves o_phase unassigned (no latch).
    o_phase = P_BAD;
    case ({i_main, i_sec, i_pea})
      {LAMP_RED,    LAMP_RED,    PEA_RED}:   o_phase = P_ALLRED;
      {LAMP_GREEN,  LAMP_RED,    PEA_RED}:   o_phase = P_MG;
      {LAMP_YELLOW, LAMP_RED,    PEA_RED}:   o_phase = P_MY;
      {LAMP_RED,    LAMP_GREEN,  PEA_RED}:   o_phase = P_SG;
      {LAMP_RED,    LAMP_YELLOW, PEA_RED}:   o_phase = P_SY;
      {LAMP_RED,    LAMP_RED,    PEA_GREEN}: o_phase = P_PG;
      default:                               o_phase = P_BAD;
    endcase
  end

endmodule

// File: rtl/tl_safety_monitor.sv
// Passive checker for the traffic-light lamp interface: conflicts, phase order and phase timing.
// Optional pedestrian statistics counter is built when TL_MON_STATS_EN is defined.
module tl_safety_monitor
  import tl_mon_pkg::*;
#(
  parameter int FPGAFREQ      = 50_000_000,
  parameter int T_GREENMAIN   = 18,
  parameter int T_YELLOWMAIN  = 4,
  parameter int T_GREENSEC    = 10,
  parameter int T_YELLOWSEC   = 3,
  parameter int T_GREENPEATON = 5,
  parameter int T_REDPEATON   = 2,
  parameter int T_TOL         = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [2:0] main_lights,
  input  logic [2:0] sec_lights,
  input  logic [1:0] pea_lights,
  input  logic       solicitud,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] phase,
  output logic [4:0] sec_in_phase,
  output logic [7:0] cycle_cnt,
  output logic [7:0] ped_served
);

  localparam int                DIV_W    = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(FPGAFREQ - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(FPGAFREQ / 2);

  phase_t           w_phase;
  phase_t           r_phase_q;
  logic             r_sol_q;
  logic [DIV_W-1:0] r_cnt_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [4:0]       r_sec_cnt;
  logic [4:0]       w_sec_nxt;
  logic             w_change;

  mon_state_t       r_state;
  mon_state_t       w_state_nxt;
  mon_state_t       w_legal_tgt;
  logic             w_legal;
  fault_t           r_fault_code;
  fault_t           w_new_fault;

  logic             w_timed;
  logic [6:0]       w_t_exp;
  logic [6:0]       w_meas;
  logic             w_short;
  logic             w_long;
  logic             w_mg_entry;
  logic             w_ped_entry;
  logic [7:0]       r_cycle_cnt;

  tl_phase_decode u_decode (
    .i_main  (main_lights),
    .i_sec   (sec_lights),
    .i_pea   (pea_lights),
    .o_phase (w_phase)
  );

  assign w_change = (w_phase != r_phase_q);

  // Timer restarts on the cycle the change is seen, so it measures time since the new phase appeared.
  always_comb begin
    w_div_nxt = r_cnt_div + DIV_W'(1);
    w_sec_nxt = r_sec_cnt;
    if (w_change) begin
      w_div_nxt = '0;
      w_sec_nxt = '0;
    end else if (r_cnt_div == DIV_MAX) begin
      w_div_nxt = '0;
      if (r_sec_cnt != SEC_MAX) w_sec_nxt = r_sec_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_phase_q <= P_ALLRED;
      r_sol_q   <= 1'b0;
      r_cnt_div <= '0;
      r_sec_cnt <= '0;
    end else begin
      r_phase_q <= w_phase;
      r_sol_q   <= solicitud;
      r_cnt_div <= w_div_nxt;
      r_sec_cnt <= w_sec_nxt;
    end
  end

  // Expected duration of the phase being left; M_RESET and M_SYNC are never timed.
  always_comb begin
    w_timed = 1'b1;
    w_t_exp = '0;
    case (r_state)
      M_MG:    w_t_exp = 7'(T_GREENMAIN);
      M_MY:    w_t_exp = 7'(T_YELLOWMAIN);
      M_SG:    w_t_exp = 7'(T_GREENSEC);
      M_SY:    w_t_exp = 7'(T_YELLOWSEC);
      M_PG:    w_t_exp = 7'(T_GREENPEATON);
      M_PR:    w_t_exp = 7'(T_REDPEATON);
      default: w_timed = 1'b0;
    endcase
  end

  assign w_meas  = 7'(r_sec_cnt) + 7'(r_cnt_div >= DIV_HALF);
  assign w_short = w_timed && ((w_meas + 7'(T_TOL)) < w_t_exp);
  assign w_long  = w_timed && (7'(w_sec_nxt) >= (w_t_exp + 7'(T_TOL) + 7'd1));

  always_comb begin
    w_legal     = 1'b0;
    w_legal_tgt = r_state;
    case (r_state)
      M_RESET: if (w_phase == P_MG)     begin w_legal = 1'b1; w_legal_tgt = M_MG; end
      M_MG:    if (w_phase == P_MY)     begin w_legal = 1'b1; w_legal_tgt = M_MY; end
      M_MY:    if (w_phase == P_SG)     begin w_legal = 1'b1; w_legal_tgt = M_SG; end
      M_SG:    if (w_phase == P_SY)     begin w_legal = 1'b1; w_legal_tgt = M_SY; end
      M_SY: begin
        if (w_phase == P_MG && !r_sol_q) begin w_legal = 1'b1; w_legal_tgt = M_MG; end
        if (w_phase == P_PG &&  r_sol_q) begin w_legal = 1'b1; w_legal_tgt = M_PG; end
      end
      M_PG:    if (w_phase == P_ALLRED) begin w_legal = 1'b1; w_legal_tgt = M_PR; end
      M_PR:    if (w_phase == P_MG)     begin w_legal = 1'b1; w_legal_tgt = M_MG; end
      default: ;
    endcase
  end

  // Checks are mutually exclusive by construction, giving CONFLICT > SEQUENCE > SHORT > LONG.
  always_comb begin
    w_state_nxt = r_state;
    w_new_fault = F_NONE;
    if (r_state != M_FAULT) begin
      if (w_phase == P_BAD) begin
        w_new_fault = F_CONFLICT;
      end else if (r_state == M_SYNC) begin
        if (w_change) w_state_nxt = sync_target(w_phase);
      end else if (w_change) begin
        if (!w_legal)     w_new_fault = F_SEQUENCE;
        else if (w_short) w_new_fault = F_SHORT;
        else              w_state_nxt = w_legal_tgt;
      end else if (w_long) begin
        w_new_fault = F_LONG;
      end
      if (w_new_fault != F_NONE) w_state_nxt = M_FAULT;
    end
    if (clr_fault) begin
      w_state_nxt = M_SYNC;
      w_new_fault = F_NONE;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= M_SYNC;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                    r_fault_code <= F_NONE;
    else if (clr_fault)             r_fault_code <= F_NONE;
    else if (w_new_fault != F_NONE) r_fault_code <= w_new_fault;
  end

  assign w_mg_entry  = (r_state != M_SYNC) && (r_state != M_MG) && (w_state_nxt == M_MG);
  assign w_ped_entry = (r_state == M_SY) && (w_state_nxt == M_PG);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)         r_cycle_cnt <= '0;
    else if (w_mg_entry) r_cycle_cnt <= r_cycle_cnt + 8'd1;
  end

`ifdef TL_MON_STATS_EN
  logic [7:0] r_ped_served;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)          r_ped_served <= '0;
    else if (w_ped_entry) r_ped_served <= r_ped_served + 8'd1;
  end

  assign ped_served = r_ped_served;
`else
  logic w_ped_entry_unused;
  assign w_ped_entry_unused = w_ped_entry;
  assign ped_served         = 8'd0;
`endif

  assign fault        = (r_fault_code != F_NONE);
  assign fault_code   = r_fault_code;
  assign phase        = r_phase_q;
  assign sec_in_phase = r_sec_cnt;
  assign cycle_cnt    = r_cycle_cnt;

endmodule

// File: tb/tb_tl_safety_monitor.sv
// Directed bench for tl_safety_monitor with FPGAFREQ=8 (one second = 8 clocks).
// Honours TL_MON_STATS_EN for the expected pedestrian counter value.
module tb_tl_safety_monitor;

  localparam int F = 8;

`ifdef TL_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;
  localparam logic [1:0] PR = 2'b10, PG = 2'b01;
  localparam logic [2:0] PH_ALLRED = 3'd0, PH_MG = 3'd1, PH_MY = 3'd2,
                         PH_SG = 3'd3, PH_SY = 3'd4, PH_PG = 3'd5;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic [2:0] main_lights = LR;
  logic [2:0] sec_lights = LR;
  logic [1:0] pea_lights = PR;
  logic       solicitud = 1'b0;
  logic       clr_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] phase;
  logic [4:0] sec_in_phase;
  logic [7:0] cycle_cnt;
  logic [7:0] ped_served;

  int total = 0;
  int bad = 0;

  tl_safety_monitor #(.FPGAFREQ(F)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .main_lights  (main_lights),
    .sec_lights   (sec_lights),
    .pea_lights   (pea_lights),
    .solicitud    (solicitud),
    .clr_fault    (clr_fault),
    .fault        (fault),
    .fault_code   (fault_code),
    .phase        (phase),
    .sec_in_phase (sec_in_phase),
    .cycle_cnt    (cycle_cnt),
    .ped_served   (ped_served)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] m;
    logic [2:0] s;
    logic [1:0] p;
    logic       sol;
    int         n;
    logic [2:0] e_phase;
    logic [4:0] e_sec;
    logic [7:0] e_cyc;
    logic [7:0] e_ped;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] m, logic [2:0] s, logic [1:0] p, logic sol, int n,
                              logic [2:0] ph, logic [4:0] sec, logic [7:0] cyc, logic [7:0] ped);
    vec_t v;
    v.m = m; v.s = s; v.p = p; v.sol = sol; v.n = n;
    v.e_phase = ph; v.e_sec = sec; v.e_cyc = cyc; v.e_ped = ped;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_lamps(input logic [2:0] m, input logic [2:0] s, input logic [1:0] p);
    main_lights = m;
    sec_lights  = s;
    pea_lights  = p;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asserts reset mid-cycle and checks outputs respond without waiting for a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    check({tag, "_rst_fault"}, 32'(fault), 0);
    check({tag, "_rst_code"},  32'(fault_code), 0);
    check({tag, "_rst_phase"}, 32'(phase), 32'(PH_ALLRED));
    check({tag, "_rst_sec"},   32'(sec_in_phase), 0);
    check({tag, "_rst_cyc"},   32'(cycle_cnt), 0);
    check({tag, "_rst_ped"},   32'(ped_served), 0);
    @(negedge clk);
    set_lamps(LR, LR, PR);
    solicitud = 1'b0;
    clr_fault = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  reached;
    int  early;
    logic [7:0] ep;

    // ---------------- table: three normal cycles, then one pedestrian cycle ----------------
    vecs.push_back(mk(LR, LR, PR, 1'b0, 4,   PH_ALLRED, 5'd0, 8'd0, 8'd0));
    vecs.push_back(mk(LG, LR, PR, 1'b0, 144, PH_MG,     5'd17, 8'd0, 8'd0));
    for (int r = 1; r <= 3; r++) begin
      vecs.push_back(mk(LY, LR, PR, 1'b0, 32,  PH_MY, 5'd3,  8'(r - 1), 8'd0));
      vecs.push_back(mk(LR, LG, PR, 1'b0, 80,  PH_SG, 5'd9,  8'(r - 1), 8'd0));
      vecs.push_back(mk(LR, LY, PR, 1'b0, 24,  PH_SY, 5'd2,  8'(r - 1), 8'd0));
      vecs.push_back(mk(LG, LR, PR, 1'b0, 144, PH_MG, 5'd17, 8'(r),     8'd0));
    end
    vecs.push_back(mk(LY, LR, PR, 1'b0, 32,  PH_MY,     5'd3,  8'd3, 8'd0));
    vecs.push_back(mk(LR, LG, PR, 1'b0, 80,  PH_SG,     5'd9,  8'd3, 8'd0));
    vecs.push_back(mk(LR, LY, PR, 1'b1, 24,  PH_SY,     5'd2,  8'd3, 8'd0));
    vecs.push_back(mk(LR, LR, PG, 1'b0, 40,  PH_PG,     5'd4,  8'd3, 8'd1));
    vecs.push_back(mk(LR, LR, PR, 1'b0, 16,  PH_ALLRED, 5'd1,  8'd3, 8'd1));
    vecs.push_back(mk(LG, LR, PR, 1'b0, 144, PH_MG,     5'd17, 8'd4, 8'd1));

    do_reset("init");
    foreach (vecs[i]) begin
      set_lamps(vecs[i].m, vecs[i].s, vecs[i].p);
      solicitud = vecs[i].sol;
      hold(vecs[i].n);
      ep = STATS ? vecs[i].e_ped : 8'd0;
      check($sformatf("v%0d_fault", i), 32'(fault), 0);
      check($sformatf("v%0d_code", i),  32'(fault_code), 0);
      check($sformatf("v%0d_phase", i), 32'(phase), 32'(vecs[i].e_phase));
      check($sformatf("v%0d_sec", i),   32'(sec_in_phase), 32'(vecs[i].e_sec));
      check($sformatf("v%0d_cyc", i),   32'(cycle_cnt), 32'(vecs[i].e_cyc));
      check($sformatf("v%0d_ped", i),   32'(ped_served), 32'(ep));
    end

    // Mid-phase reset with non-zero counters.
    hold(3);
    do_reset("midphase");

    // ---------------- conflict: both greens for a single cycle ----------------
    hold(4);
    set_lamps(LG, LR, PR);
    hold(16);
    set_lamps(LG, LG, PR);
    #1 check("conf_not_yet", 32'(fault), 0);
    @(negedge clk);
    set_lamps(LG, LR, PR);
    check("conf_fault", 32'(fault), 1);
    check("conf_code",  32'(fault_code), 1);
    hold(8);
    check("conf_sticky", 32'(fault_code), 1);
    check("conf_phase",  32'(phase), 32'(PH_MG));

    // ---------------- long: hold main green past 18+1 seconds ----------------
    do_reset("long");
    hold(4);
    set_lamps(LG, LR, PR);
    reached = 0;
    early   = 0;
    for (int i = 0; i < 400 && reached == 0; i++) begin
      @(negedge clk);
      if (sec_in_phase == 5'd20) reached = 1;
      else if (fault) early = 1;
    end
    check("long_reached",  reached, 1);
    check("long_no_early", early, 0);
    check("long_code",     32'(fault_code), 4);
    check("long_phase",    32'(phase), 32'(PH_MG));

    // ---------------- short, stickiness, clear and resync ----------------
    do_reset("short");
    hold(4);
    set_lamps(LG, LR, PR);
    hold(16);
    set_lamps(LY, LR, PR);
    @(negedge clk);
    check("short_code", 32'(fault_code), 3);
    set_lamps(LR, LR, PG);
    hold(8);
    check("short_keep_code",  32'(fault_code), 3);
    check("short_keep_fault", 32'(fault), 1);
    check("short_phase_upd",  32'(phase), 32'(PH_PG));
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    check("clr_fault", 32'(fault), 0);
    check("clr_code",  32'(fault_code), 0);
    set_lamps(LR, LG, PR);
    hold(8);
    check("sync_adopt_sg", 32'(fault), 0);
    set_lamps(LG, LR, PR);
    hold(4);
    check("sg_to_mg_seq", 32'(fault_code), 2);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b1;
    set_lamps(LG, LG, PR);
    @(negedge clk);
    clr_fault = 1'b0;
    set_lamps(LG, LR, PR);
    check("clr_wins", 32'(fault), 0);
    hold(4);
    check("clr_wins_after", 32'(fault), 0);
    check("clr_wins_phase", 32'(phase), 32'(PH_MG));

    // ---------------- sequence: SY->MG while the request is still up ----------------
    do_reset("seq");
    hold(4);
    set_lamps(LR, LY, PR);
    solicitud = 1'b1;
    hold(24);
    set_lamps(LG, LR, PR);
    @(negedge clk);
    check("seq_code", 32'(fault_code), 2);
    hold(5);
    check("seq_cyc_frozen", 32'(cycle_cnt), 0);
    do_reset("seq_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
